// File: rtl/pkt_injector0_if.sv
// Handshake bundle between the processing element, the injector and the router local port.
// The slave view belongs to the injector; master is the PE/router side.
interface pkt_injector0_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_dest;
  logic [2:0]  req_len;
  logic        pld_valid;
  logic        pld_ready;
  logic [9:0]  pld_data;
  logic [15:0] Lo;
  logic        Lo_valid;
  logic        Lo_ready;
  logic        pkt_done;
  logic        err_len;

  modport slave (
    input  req_valid, req_dest, req_len, pld_valid, pld_data, Lo_ready,
    output req_ready, pld_ready, Lo, Lo_valid, pkt_done, err_len
  );

  modport master (
    output req_valid, req_dest, req_len, pld_valid, pld_data, Lo_ready,
    input  req_ready, pld_ready, Lo, Lo_valid, pkt_done, err_len
  );
endinterface

// File: rtl/pkt_injector0.sv
// Local-port packet injector: turns a request plus payload words into HDR/BODY/TAIL
// flits behind a single output register with valid/ready backpressure.
module pkt_injector0 #(
  parameter logic [3:0] SRC_ADDR = 4'd1,
  parameter int         MAX_LEN  = 7
) (
  input logic            clk,
  input logic            rst,
  pkt_injector0_if.slave bus
);
  localparam logic [1:0] T_HDR  = 2'b10;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [3:0] MAX_L  = 4'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, PLD, WAIT_TAIL} state_t;

  state_t      r_state;
  logic [15:0] r_lo;
  logic        r_lo_valid;
  logic        r_pkt_done;
  logic        r_err_len;
  logic [2:0]  r_seq;
  logic [2:0]  r_rem;
  logic [3:0]  r_dest;

  logic w_can_load;
  logic w_pld_ready;
  logic w_pld_fire;
  logic w_len_bad;

  // Output register is free when empty or when its current flit leaves this cycle.
  assign w_can_load  = !r_lo_valid || bus.Lo_ready;
  assign w_pld_ready = (r_state == PLD) && w_can_load;
  assign w_pld_fire  = bus.pld_valid && w_pld_ready;
  assign w_len_bad   = (bus.req_len == 3'd0) || ({1'b0, bus.req_len} > MAX_L);

  assign bus.req_ready = (r_state == IDLE);
  assign bus.pld_ready = w_pld_ready;
  assign bus.Lo        = r_lo;
  assign bus.Lo_valid  = r_lo_valid;
  assign bus.pkt_done  = r_pkt_done;
  assign bus.err_len   = r_err_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lo       <= 16'h0;
      r_lo_valid <= 1'b0;
      r_pkt_done <= 1'b0;
      r_err_len  <= 1'b0;
      r_seq      <= 3'd0;
      r_rem      <= 3'd0;
      r_dest     <= 4'd0;
    end else begin
      r_pkt_done <= 1'b0;
      r_err_len  <= 1'b0;
      unique case (r_state)
        // Output register is always empty here, so the header loads unconditionally.
        IDLE: begin
          if (bus.req_valid) begin
            if (w_len_bad) begin
              r_err_len <= 1'b1;
            end else begin
              r_dest     <= bus.req_dest;
              r_rem      <= bus.req_len;
              r_lo       <= {T_HDR, SRC_ADDR, bus.req_len, r_seq, bus.req_dest};
              r_lo_valid <= 1'b1;
              r_state    <= PLD;
            end
          end
        end
        PLD: begin
          if (w_pld_fire) begin
            r_lo       <= {(r_rem == 3'd1) ? T_TAIL : T_BODY, bus.pld_data, r_dest};
            r_lo_valid <= 1'b1;
            r_rem      <= r_rem - 3'd1;
            if (r_rem == 3'd1) r_state <= WAIT_TAIL;
          end else if (bus.Lo_ready) begin
            r_lo_valid <= 1'b0;
          end
        end
        WAIT_TAIL: begin
          if (r_lo_valid && bus.Lo_ready) begin
            r_lo_valid <= 1'b0;
            r_pkt_done <= 1'b1;
            r_seq      <= r_seq + 3'd1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pkt_injector0.sv
// Scoreboard bench for pkt_injector0: stimulus pushes expected flits, a negedge monitor
// pops and compares on every Lo handshake and checks the pkt_done pulse after each tail.
module tb_pkt_injector0;
  localparam logic [3:0] SRC = 4'd1;

  logic clk = 1'b0;
  logic rst;
  pkt_injector0_if bus();

  pkt_injector0 #(.SRC_ADDR(SRC), .MAX_LEN(7)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] q[$];
  logic [9:0]  pd[7];
  logic [2:0]  m_seq = 3'd0;
  bit          gap_chk = 1'b0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] hdr(input logic [3:0] d, input logic [2:0] l, input logic [2:0] s);
    return {2'b10, SRC, l, s, d};
  endfunction

  task automatic monitor();
    int cyc = 0;
    int last_tail = -1;
    bit exp_done = 1'b0;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!gap_chk) last_tail = -1;
      if (rst) begin
        exp_done = 1'b0;
      end else begin
        if (exp_done || bus.pkt_done) chk("pkt_done", 32'(bus.pkt_done), 32'(exp_done));
        exp_done = 1'b0;
        if (bus.Lo_valid && bus.Lo_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_flit", 32'(bus.Lo), 32'hDEAD);
          end else begin
            e = q.pop_front();
            chk("flit", 32'(bus.Lo), 32'(e));
          end
          if (bus.Lo[15:14] == 2'b10 && gap_chk && last_tail >= 0)
            chk("tail_to_hdr_cycles", 32'(cyc - last_tail), 32'd2);
          if (bus.Lo[15:14] == 2'b01) begin
            exp_done = 1'b1;
            last_tail = cyc;
          end
        end
      end
    end
  endtask

  task automatic do_req(input logic [3:0] d, input logic [2:0] l);
    bit acc = 1'b0;
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_dest  = d;
    bus.req_len   = l;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.req_valid = 1'b0;
    if (!acc) chk("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [9:0] w);
    bit acc = 1'b0;
    int n = 0;
    bus.pld_valid = 1'b1;
    bus.pld_data  = w;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.pld_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.pld_valid = 1'b0;
    if (!acc) chk("pld_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_pkt(input logic [3:0] d, input logic [2:0] l, input bit gap);
    q.push_back(hdr(d, l, m_seq));
    for (int i = 0; i < int'(l); i++)
      q.push_back({(i == int'(l) - 1) ? 2'b01 : 2'b00, pd[i], d});
    m_seq = m_seq + 3'd1;
    do_req(d, l);
    for (int i = 0; i < int'(l); i++) begin
      send_word(pd[i]);
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic stall_proc();
    bit found = 1'b0;
    int n = 0;
    logic [15:0] held;
    while (!found && n < 200) begin
      @(posedge clk);
      #2;
      found = bus.Lo_valid && (bus.Lo[15:14] == 2'b00);
      n++;
    end
    if (!found) chk("stall_timeout", 32'd0, 32'd1);
    bus.Lo_ready = 1'b0;
    held = bus.Lo;
    repeat (3) begin
      @(negedge clk);
      chk("stall_lo", 32'(bus.Lo), 32'(held));
      chk("stall_lo_valid", 32'(bus.Lo_valid), 32'd1);
      chk("stall_pld_ready", 32'(bus.pld_ready), 32'd0);
      @(posedge clk);
      #2;
    end
    bus.Lo_ready = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_dest = 4'd0; bus.req_len = 3'd0;
    bus.pld_valid = 1'b0; bus.pld_data = 10'd0; bus.Lo_ready = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_Lo", 32'(bus.Lo), 32'h0);
    chk("rst_Lo_valid", 32'(bus.Lo_valid), 32'd0);
    chk("rst_pkt_done", 32'(bus.pkt_done), 32'd0);
    chk("rst_err_len", 32'(bus.err_len), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rst_pld_ready", 32'(bus.pld_ready), 32'd0);
    @(posedge clk);
    #1;

    // Rejected len=0 request: one err_len pulse, no flits, seq untouched.
    do_req(4'd2, 3'd0);
    @(negedge clk);
    chk("err_len_pulse", 32'(bus.err_len), 32'd1);
    chk("err_no_flit", 32'(bus.Lo_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("err_len_clear", 32'(bus.err_len), 32'd0);
    chk("err_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;

    // dest=3 len=2 seq=0: header 10_0001_010_000_0011 = 16'h8503.
    q.push_back(16'h8503);
    q.push_back(16'h1553);
    q.push_back(16'h4AA3);
    m_seq = m_seq + 3'd1;
    do_req(4'd3, 3'd2);
    send_word(10'h155);
    send_word(10'h0AA);
    drain();

    // Backpressure in the middle of a len=4 body.
    pd[0] = 10'h011; pd[1] = 10'h022; pd[2] = 10'h033; pd[3] = 10'h044;
    fork
      run_pkt(4'd9, 3'd4, 1'b0);
      stall_proc();
    join
    drain();

    // Reset after header and one body flit have left.
    q.push_back(hdr(4'd5, 3'd3, m_seq));
    q.push_back({2'b00, 10'h2F0, 4'd5});
    do_req(4'd5, 3'd3);
    send_word(10'h2F0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_seq = 3'd0;
    @(negedge clk);
    chk("midrst_Lo_valid", 32'(bus.Lo_valid), 32'd0);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_queue", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Nine back-to-back len=1 packets: seq 0..7 then 0, one idle cycle between packets.
    gap_chk = 1'b1;
    for (int k = 0; k < 9; k++) begin
      pd[0] = 10'h300 + 10'(k);
      run_pkt(4'(k), 3'd1, 1'b0);
    end
    drain();
    gap_chk = 1'b0;

    // len=7 with pld_valid dropping every other cycle.
    for (int i = 0; i < 7; i++) pd[i] = 10'h1A0 + 10'(i * 17);
    run_pkt(4'hA, 3'd7, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
